bank_write_ctrl: RTL and testbench
==================================

Name: bank_write_ctrl

Overview:
Ingress-side writer for one port's shared packet-buffer bank. It accepts a word stream of received frames and writes each word into the bank SRAM as a circular buffer. On a good frame end it emits a descriptor (start address, length in words) to the forwarding logic. It drops a frame and rewinds the write pointer on error, on overflow, on an oversize frame, or when the descriptor slot is busy. Downstream releases buffer space in frame order.

Parameters:
DATA_WIDTH, 32, word width of the stream and the SRAM.
DEPTH, 4608, SRAM depth in words. Need not be a power of two.
MAX_FRAME_WORDS, 381, largest legal frame in words.
ADDR_W, $clog2(DEPTH), address width (derived).
LEN_W, $clog2(MAX_FRAME_WORDS+1), length width (derived).

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  stream word valid; no backpressure, always accepted
i_data  in  DATA_WIDTH  stream word
i_last  in  1  final word of the frame, qualified by i_valid
i_err  in  1  frame bad (CRC/PHY error), qualified by i_valid; sampled on any word
o_wr  out  1  SRAM write strobe (to i_write)
o_addr_wr  out  ADDR_W  SRAM write address
o_data  out  DATA_WIDTH  SRAM write data
o_desc_valid  out  1  descriptor available
i_desc_ready  in  1  descriptor consumed when high together with o_desc_valid
o_desc_addr  out  ADDR_W  frame start address
o_desc_len  out  LEN_W  frame length in words
i_release  in  1  pulse: oldest committed frame freed
i_release_len  in  LEN_W  words freed by i_release
o_used  out  ADDR_W+1  committed words currently held
o_frame_cnt  out  16  committed frames, saturating
o_drop_cnt  out  16  dropped frames, saturating

Behaviour:
- Reset values: all outputs 0. Write pointer (wp), frame start (fs), in-flight count (inf) and used are 0. FSM is IDLE.
- Single clock; all outputs registered.
- FSM states:
  - IDLE: on i_valid, set fs = wp and start the frame.
    - i_err, or the overflow condition → DROP (or stay IDLE if i_last).
    - Otherwise write the word; go to WRITE, or commit if i_last (single-word frame).
  - WRITE: each i_valid writes the word.
    - Drop conditions, evaluated on the incoming word:
      - i_err
      - used + inf == DEPTH (overflow)
      - inf == MAX_FRAME_WORDS (oversize)
      - i_last while o_desc_valid is high and i_desc_ready is low (slot busy)
    - On drop: set wp = fs, inf = 0, o_drop_cnt++. Go to DROP, or IDLE if i_last. Write nothing for that word.
    - Good i_last: commit, then IDLE.
  - DROP: discard words until i_last, then IDLE. No writes occur.
- Write timing: a word accepted in cycle N appears as o_wr/o_addr_wr/o_data in N+1. wp then increments, wrapping DEPTH-1 → 0 by explicit compare.
- Commit (last word in cycle N):
  - o_desc_valid rises in N+2, after the SRAM write has landed.
  - o_desc_addr = fs; o_desc_len = inf including the last word.
  - used += len; o_frame_cnt++; inf = 0.
- Descriptor handshake: o_desc_valid falls the cycle after o_desc_valid && i_desc_ready. A handshake in the same cycle as a new commit frees the slot, so the new frame is not dropped.
- Release: used -= i_release_len. If release and commit fall in the same cycle, used = used + len - rel. Release with i_release_len > used is a protocol violation; flag it with an assertion only.
- Rewind on drop: in-flight words already written are abandoned. Those addresses are reused by the next frame.
- Counters saturate at 0xFFFF.
- Reset mid-frame: everything returns to reset values immediately. A partial frame is neither counted nor dropped.

Test Plan:
- Frame of 4 words, data 0xA0..0xA3, after reset:
  - o_wr at addr 0..3 with those data.
  - o_desc_valid 2 cycles after last with addr 0, len 4.
  - o_used = 4, o_frame_cnt = 1.
- Wrap-around: preset wp = 4606 via prior frames plus release, then a 5-word frame → writes to 4606, 4607, 0, 1, 2; o_desc_addr = 4606, len 5.
- i_err on word 3 of a 6-word frame → no writes after word 2, o_drop_cnt = 1. The next frame starts at the same fs address. No descriptor is emitted for the dropped frame.
- Overflow: used = 4604 with no release, then a 6-word frame → drop on word 5. wp rewinds, o_used stays 4604. After i_release of 4604, a retry frame commits.
- Oversize: 382-word frame → drop at word 382, o_drop_cnt++. A 381-word frame commits with len 381.
- Descriptor slot busy:
  - Two back-to-back 1-word frames with i_desc_ready = 0 → second frame dropped.
  - Repeat with i_desc_ready = 1 in the second frame's last cycle → both committed.
  - Simultaneous release and commit → used correct.

Source files
------------

// File: rtl/bank_write_ctrl.sv
// bank_write_ctrl: ingress writer for one port's shared packet-buffer bank.
// Stores each received frame word-by-word into a circular SRAM region. Good
// frames are published as (start, length) descriptors. Bad, overflowing,
// oversize or slot-blocked frames are dropped and their space is reclaimed
// by rewinding the write pointer.
module bank_write_ctrl #(
  parameter int DATA_WIDTH      = 32,
  parameter int DEPTH           = 4608,
  parameter int MAX_FRAME_WORDS = 381,
  parameter int ADDR_W          = $clog2(DEPTH),
  parameter int LEN_W           = $clog2(MAX_FRAME_WORDS + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_last,
  input  logic                  i_err,
  output logic                  o_wr,
  output logic [ADDR_W-1:0]     o_addr_wr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_desc_valid,
  input  logic                  i_desc_ready,
  output logic [ADDR_W-1:0]     o_desc_addr,
  output logic [LEN_W-1:0]      o_desc_len,
  input  logic                  i_release,
  input  logic [LEN_W-1:0]      i_release_len,
  output logic [ADDR_W:0]       o_used,
  output logic [15:0]           o_frame_cnt,
  output logic [15:0]           o_drop_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);
  localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(MAX_FRAME_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_DROP
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       wp_q, wp_d;
  logic [ADDR_W-1:0]       fs_q, fs_d;
  logic [LEN_W-1:0]        inf_q, inf_d;
  logic [ADDR_W:0]         used_q, used_d;
  logic                    wr_q, wr_d;
  logic [ADDR_W-1:0]       addr_wr_q, addr_wr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  // Commit staged for one cycle so the descriptor trails the last SRAM write.
  logic                    pend_q, pend_d;
  logic [ADDR_W-1:0]       pend_addr_q, pend_addr_d;
  logic [LEN_W-1:0]        pend_len_q, pend_len_d;
  logic                    desc_valid_q, desc_valid_d;
  logic [ADDR_W-1:0]       desc_addr_q, desc_addr_d;
  logic [LEN_W-1:0]        desc_len_q, desc_len_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;
  logic [15:0]             drop_cnt_q, drop_cnt_d;

  logic                    commit;
  logic                    drop;
  logic                    slot_busy;
  logic [ADDR_W-1:0]       frame_fs;
  logic [ADDR_W-1:0]       wp_inc;
  logic [LEN_W-1:0]        commit_len;

  // Frame FSM: accept, write, drop or commit each incoming word.
  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    wp_d       = wp_q;
    fs_d       = fs_q;
    inf_d      = inf_q;
    wr_d       = 1'b0;
    addr_wr_d  = addr_wr_q;
    data_d     = data_q;
    commit     = 1'b0;
    drop       = 1'b0;
    frame_fs   = (state_q == ST_IDLE) ? wp_q : fs_q;
    wp_inc     = (wp_q == LAST_ADDR) ? '0 : wp_q + ADDR_W'(1);
    commit_len = inf_q + LEN_W'(1);
    // A pending commit or an unconsumed descriptor occupies the single slot.
    slot_busy  = pend_q || (desc_valid_q && !i_desc_ready);

    case (state_q)
      ST_IDLE, ST_WRITE: begin
        if (i_valid) begin
          // inf_q is always zero in IDLE, so the same drop test covers both states.
          drop = i_err
              || ((used_q + (ADDR_W + 1)'(inf_q)) == DEPTH_W)
              || (inf_q == MAX_LEN)
              || (i_last && slot_busy);
          fs_d = frame_fs;
          if (drop) begin
            wp_d    = frame_fs;
            inf_d   = '0;
            state_d = i_last ? ST_IDLE : ST_DROP;
          end else begin
            wr_d      = 1'b1;
            addr_wr_d = wp_q;
            data_d    = i_data;
            wp_d      = wp_inc;
            if (i_last) begin
              commit  = 1'b1;
              inf_d   = '0;
              state_d = ST_IDLE;
            end else begin
              inf_d   = commit_len;
              state_d = ST_WRITE;
            end
          end
        end
      end
      ST_DROP: begin
        if (i_valid && i_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Descriptor slot, buffer occupancy and statistics.
  always_comb begin
    pend_d       = commit;
    pend_addr_d  = commit ? frame_fs : pend_addr_q;
    pend_len_d   = commit ? commit_len : pend_len_q;
    desc_valid_d = desc_valid_q;
    desc_addr_d  = desc_addr_q;
    desc_len_d   = desc_len_q;
    if (pend_q) begin
      desc_valid_d = 1'b1;
      desc_addr_d  = pend_addr_q;
      desc_len_d   = pend_len_q;
    end else if (desc_valid_q && i_desc_ready) begin
      desc_valid_d = 1'b0;
    end
    used_d = used_q
           + (commit    ? (ADDR_W + 1)'(commit_len)    : '0)
           - (i_release ? (ADDR_W + 1)'(i_release_len) : '0);
    frame_cnt_d = (commit && frame_cnt_q != 16'hFFFF) ? frame_cnt_q + 16'd1 : frame_cnt_q;
    drop_cnt_d  = (drop   && drop_cnt_q  != 16'hFFFF) ? drop_cnt_q  + 16'd1 : drop_cnt_q;
  end

  // State and output registers.
  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      wp_q         <= '0;
      fs_q         <= '0;
      inf_q        <= '0;
      used_q       <= '0;
      wr_q         <= 1'b0;
      addr_wr_q    <= '0;
      data_q       <= '0;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      pend_len_q   <= '0;
      desc_valid_q <= 1'b0;
      desc_addr_q  <= '0;
      desc_len_q   <= '0;
      frame_cnt_q  <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      wp_q         <= wp_d;
      fs_q         <= fs_d;
      inf_q        <= inf_d;
      used_q       <= used_d;
      wr_q         <= wr_d;
      addr_wr_q    <= addr_wr_d;
      data_q       <= data_d;
      pend_q       <= pend_d;
      pend_addr_q  <= pend_addr_d;
      pend_len_q   <= pend_len_d;
      desc_valid_q <= desc_valid_d;
      desc_addr_q  <= desc_addr_d;
      desc_len_q   <= desc_len_d;
      frame_cnt_q  <= frame_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Releasing more words than are held is a downstream protocol violation.
  release_within_used: assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
      i_release |-> ((ADDR_W + 1)'(i_release_len) <= used_q)
  );

  assign o_wr         = wr_q;
  assign o_addr_wr    = addr_wr_q;
  assign o_data       = data_q;
  assign o_desc_valid = desc_valid_q;
  assign o_desc_addr  = desc_addr_q;
  assign o_desc_len   = desc_len_q;
  assign o_used       = used_q;
  assign o_frame_cnt  = frame_cnt_q;
  assign o_drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_bank_write_ctrl.sv
// Testbench for bank_write_ctrl: directed scenarios plus randomized frames,
// scored against a frame-level reference model of the buffer bank.
module tb_bank_write_ctrl;

  localparam int DEPTH = 4608;
  localparam int MAXW  = 381;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic [31:0] i_data;
  logic        i_last;
  logic        i_err;
  logic        o_wr;
  logic [12:0] o_addr_wr;
  logic [31:0] o_data;
  logic        o_desc_valid;
  logic        i_desc_ready;
  logic [12:0] o_desc_addr;
  logic [8:0]  o_desc_len;
  logic        i_release;
  logic [8:0]  i_release_len;
  logic [13:0] o_used;
  logic [15:0] o_frame_cnt;
  logic [15:0] o_drop_cnt;

  bank_write_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_valid(i_valid), .i_data(i_data), .i_last(i_last), .i_err(i_err),
    .o_wr(o_wr), .o_addr_wr(o_addr_wr), .o_data(o_data),
    .o_desc_valid(o_desc_valid), .i_desc_ready(i_desc_ready),
    .o_desc_addr(o_desc_addr), .o_desc_len(o_desc_len),
    .i_release(i_release), .i_release_len(i_release_len),
    .o_used(o_used), .o_frame_cnt(o_frame_cnt), .o_drop_cnt(o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  int checks, errors;
  int cyc;
  bit rand_mode;

  // Reference model: buffer pointers, occupancy, counters, descriptor slot.
  int  m_wp, m_fs, m_inf, m_used, m_frames, m_drops;
  bit  m_in_frame, m_dropping;
  bit  m_slot_full;
  int  m_slot_cyc, m_slot_addr, m_slot_len;
  int  committed_q[$];

  task automatic model_reset();
    m_wp = 0; m_fs = 0; m_inf = 0; m_used = 0; m_frames = 0; m_drops = 0;
    m_in_frame = 0; m_dropping = 0; m_slot_full = 0;
    m_slot_cyc = 0; m_slot_addr = 0; m_slot_len = 0;
    committed_q.delete();
  endtask

  // One clock: apply the model to the inputs presented now, advance, score outputs.
  task automatic step();
    bit hs, drop, commit, exp_wr, exp_dv;
    int exp_addr;
    logic [31:0] exp_data;
    if (rand_mode) begin
      i_desc_ready = ($urandom_range(0, 1) == 1);
      if (!i_release && committed_q.size() > 0 && $urandom_range(0, 9) < 3) begin
        i_release     = 1'b1;
        i_release_len = 9'(committed_q.pop_front());
      end
    end
    exp_wr = 0; exp_addr = 0; exp_data = '0; commit = 0;
    hs = m_slot_full && (cyc >= m_slot_cyc + 2) && i_desc_ready;
    if (i_valid) begin
      if (m_dropping) begin
        if (i_last) m_dropping = 0;
      end else begin
        if (!m_in_frame) m_fs = m_wp;
        drop = i_err || (m_used + m_inf == DEPTH) || (m_inf == MAXW)
            || (i_last && m_slot_full && !hs);
        if (drop) begin
          m_wp = m_fs; m_inf = 0; m_in_frame = 0; m_dropping = !i_last;
          if (m_drops < 65535) m_drops++;
        end else begin
          exp_wr = 1; exp_addr = m_wp; exp_data = i_data;
          m_wp = (m_wp + 1) % DEPTH;
          m_inf++;
          m_in_frame = !i_last;
          commit = i_last;
        end
      end
    end
    if (hs) m_slot_full = 0;
    if (commit) begin
      m_slot_full = 1; m_slot_cyc = cyc; m_slot_addr = m_fs; m_slot_len = m_inf;
      m_used += m_inf;
      committed_q.push_back(m_inf);
      if (m_frames < 65535) m_frames++;
      m_inf = 0;
    end
    if (i_release) m_used -= int'(i_release_len);

    @(posedge i_clk); #1;
    cyc++;
    i_release = 1'b0;

    checks++;
    if (o_wr !== exp_wr) begin
      errors++;
      $display("FAIL wr_strobe cyc %0d: got %0b expected %0b", cyc, o_wr, exp_wr);
    end else if (exp_wr) begin
      checks++;
      if (o_addr_wr !== 13'(exp_addr) || o_data !== exp_data) begin
        errors++;
        $display("FAIL wr_word cyc %0d: got addr %0d data %h expected addr %0d data %h",
                 cyc, o_addr_wr, o_data, exp_addr, exp_data);
      end
    end
    exp_dv = m_slot_full && (cyc >= m_slot_cyc + 2);
    checks++;
    if (o_desc_valid !== exp_dv) begin
      errors++;
      $display("FAIL desc_valid cyc %0d: got %0b expected %0b", cyc, o_desc_valid, exp_dv);
    end else if (exp_dv) begin
      checks++;
      if (o_desc_addr !== 13'(m_slot_addr) || o_desc_len !== 9'(m_slot_len)) begin
        errors++;
        $display("FAIL desc_fields cyc %0d: got addr %0d len %0d expected addr %0d len %0d",
                 cyc, o_desc_addr, o_desc_len, m_slot_addr, m_slot_len);
      end
    end
  endtask

  task automatic idle(input int n);
    i_valid = 0; i_last = 0; i_err = 0;
    repeat (n) step();
  endtask

  task automatic send_frame(input int len, input int err_at);
    for (int w = 1; w <= len; w++) begin
      i_valid = 1; i_data = $urandom; i_last = (w == len); i_err = (w == err_at);
      step();
    end
    i_valid = 0; i_last = 0; i_err = 0;
  endtask

  // Hand over every outstanding descriptor and release all committed frames.
  task automatic drain();
    i_valid = 0; i_last = 0; i_err = 0; i_desc_ready = 1;
    while (committed_q.size() > 0) begin
      i_release = 1; i_release_len = 9'(committed_q.pop_front());
      step();
    end
    repeat (3) step();
    i_desc_ready = 0;
  endtask

  task automatic test_reset();
    i_rst_n = 0;
    repeat (2) @(posedge i_clk);
    #1;
    checks++;
    if ({o_wr, o_addr_wr, o_data, o_desc_valid, o_desc_addr, o_desc_len} !== '0) begin
      errors++;
      $display("FAIL reset_datapath: got nonzero %h", {o_wr, o_addr_wr, o_data, o_desc_valid, o_desc_addr, o_desc_len});
    end
    checks++;
    if ({o_used, o_frame_cnt, o_drop_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_counters: got used %0d frames %0d drops %0d expected 0", o_used, o_frame_cnt, o_drop_cnt);
    end
    model_reset();
    #2 i_rst_n = 1;
  endtask

  task automatic test_basic();
    i_desc_ready = 0;
    for (int i = 0; i < 4; i++) begin
      i_valid = 1; i_data = 32'hA0 + 32'(i); i_last = (i == 3); i_err = 0;
      step();
      checks++;
      if (o_wr !== 1'b1 || o_addr_wr !== 13'(i) || o_data !== 32'hA0 + 32'(i)) begin
        errors++;
        $display("FAIL basic_write %0d: got wr %0b addr %0d data %h expected 1 %0d %h",
                 i, o_wr, o_addr_wr, o_data, i, 32'hA0 + 32'(i));
      end
    end
    i_valid = 0; i_last = 0;
    checks++;
    if (o_desc_valid !== 1'b0) begin
      errors++; $display("FAIL basic_desc_early: got %0b expected 0", o_desc_valid);
    end
    idle(1);
    checks++;
    if (o_desc_valid !== 1'b1 || o_desc_addr !== 13'd0 || o_desc_len !== 9'd4) begin
      errors++;
      $display("FAIL basic_desc: got valid %0b addr %0d len %0d expected 1 0 4", o_desc_valid, o_desc_addr, o_desc_len);
    end
    checks++;
    if (o_used !== 14'd4 || o_frame_cnt !== 16'd1 || o_drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL basic_counts: got used %0d frames %0d drops %0d expected 4 1 0", o_used, o_frame_cnt, o_drop_cnt);
    end
    drain();
  endtask

  task automatic test_err();
    for (int w = 1; w <= 6; w++) begin
      i_valid = 1; i_data = 32'hB0 + 32'(w); i_last = (w == 6); i_err = (w == 3);
      step();
      checks++;
      if (o_wr !== (w <= 2)) begin
        errors++; $display("FAIL err_write word %0d: got %0b expected %0b", w, o_wr, (w <= 2));
      end
    end
    idle(3);
    checks++;
    if (o_drop_cnt !== 16'd1 || o_desc_valid !== 1'b0) begin
      errors++; $display("FAIL err_drop: got drops %0d desc_valid %0b expected 1 0", o_drop_cnt, o_desc_valid);
    end
    send_frame(2, 0);
    idle(1);
    checks++;
    if (o_desc_valid !== 1'b1 || o_desc_addr !== 13'd4 || o_desc_len !== 9'd2) begin
      errors++;
      $display("FAIL err_retry_desc: got valid %0b addr %0d len %0d expected 1 4 2", o_desc_valid, o_desc_addr, o_desc_len);
    end
    drain();
  endtask

  task automatic test_wrap();
    int fill;
    int wa[5];
    wa = '{4606, 4607, 0, 1, 2};
    fill = (4606 - m_wp + DEPTH) % DEPTH;
    while (fill > 0) begin
      send_frame((fill > MAXW) ? MAXW : fill, 0);
      fill -= (fill > MAXW) ? MAXW : fill;
      drain();
    end
    for (int w = 0; w < 5; w++) begin
      i_valid = 1; i_data = $urandom; i_last = (w == 4); i_err = 0;
      step();
      checks++;
      if (o_wr !== 1'b1 || o_addr_wr !== 13'(wa[w])) begin
        errors++; $display("FAIL wrap_addr %0d: got wr %0b addr %0d expected 1 %0d", w, o_wr, o_addr_wr, wa[w]);
      end
    end
    idle(2);
    checks++;
    if (o_desc_valid !== 1'b1 || o_desc_addr !== 13'd4606 || o_desc_len !== 9'd5) begin
      errors++;
      $display("FAIL wrap_desc: got valid %0b addr %0d len %0d expected 1 4606 5", o_desc_valid, o_desc_addr, o_desc_len);
    end
    drain();
  endtask

  task automatic test_overflow();
    int fill, d0, fs_rec;
    i_desc_ready = 1;
    fill = 4604;
    while (fill > 0) begin
      send_frame((fill > MAXW) ? MAXW : fill, 0);
      fill -= (fill > MAXW) ? MAXW : fill;
      idle(2);
    end
    d0 = m_drops; fs_rec = m_wp;
    for (int w = 1; w <= 6; w++) begin
      i_valid = 1; i_data = $urandom; i_last = (w == 6); i_err = 0;
      step();
      checks++;
      if (o_wr !== (w <= 4)) begin
        errors++; $display("FAIL ovf_write word %0d: got %0b expected %0b", w, o_wr, (w <= 4));
      end
    end
    idle(3);
    checks++;
    if (o_used !== 14'd4604 || o_drop_cnt !== 16'(d0 + 1)) begin
      errors++;
      $display("FAIL ovf_state: got used %0d drops %0d expected 4604 %0d", o_used, o_drop_cnt, d0 + 1);
    end
    drain();
    send_frame(6, 0);
    idle(1);
    checks++;
    if (o_desc_valid !== 1'b1 || o_desc_addr !== 13'(fs_rec) || o_desc_len !== 9'd6) begin
      errors++;
      $display("FAIL ovf_retry_desc: got valid %0b addr %0d len %0d expected 1 %0d 6", o_desc_valid, o_desc_addr, o_desc_len, fs_rec);
    end
    drain();
  endtask

  task automatic test_oversize();
    int d0;
    d0 = m_drops;
    for (int w = 1; w <= MAXW + 1; w++) begin
      i_valid = 1; i_data = $urandom; i_last = (w == MAXW + 1); i_err = 0;
      step();
      if (w >= MAXW) begin
        checks++;
        if (o_wr !== (w == MAXW)) begin
          errors++; $display("FAIL oversize_write word %0d: got %0b expected %0b", w, o_wr, (w == MAXW));
        end
      end
    end
    idle(2);
    checks++;
    if (o_drop_cnt !== 16'(d0 + 1) || o_desc_valid !== 1'b0) begin
      errors++; $display("FAIL oversize_drop: got drops %0d valid %0b expected %0d 0", o_drop_cnt, o_desc_valid, d0 + 1);
    end
    send_frame(MAXW, 0);
    idle(1);
    checks++;
    if (o_desc_valid !== 1'b1 || o_desc_len !== 9'd381) begin
      errors++; $display("FAIL max_frame_desc: got valid %0b len %0d expected 1 381", o_desc_valid, o_desc_len);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int f0, d0, a2, u0, rel;
    f0 = m_frames; d0 = m_drops;
    i_desc_ready = 0;
    i_valid = 1; i_last = 1; i_err = 0; i_data = 32'h11; step();
    i_data = 32'h22; step();
    idle(3);
    checks++;
    if (o_frame_cnt !== 16'(f0 + 1) || o_drop_cnt !== 16'(d0 + 1) || o_desc_len !== 9'd1) begin
      errors++;
      $display("FAIL busy_drop: got frames %0d drops %0d len %0d expected %0d %0d 1", o_frame_cnt, o_drop_cnt, o_desc_len, f0 + 1, d0 + 1);
    end
    i_desc_ready = 1; step(); i_desc_ready = 0; idle(2);
    f0 = m_frames; d0 = m_drops;
    i_valid = 1; i_last = 1; i_data = 32'h33; step();
    idle(1);
    a2 = m_wp;
    i_valid = 1; i_last = 1; i_data = 32'h44; i_desc_ready = 1; step();
    i_desc_ready = 0;
    idle(2);
    checks++;
    if (o_frame_cnt !== 16'(f0 + 2) || o_drop_cnt !== 16'(d0) || o_desc_valid !== 1'b1 || o_desc_addr !== 13'(a2)) begin
      errors++;
      $display("FAIL handshake_commit: got frames %0d drops %0d valid %0b addr %0d expected %0d %0d 1 %0d",
               o_frame_cnt, o_drop_cnt, o_desc_valid, o_desc_addr, f0 + 2, d0, a2);
    end
    i_desc_ready = 1; step(); i_desc_ready = 0; idle(2);
    u0 = m_used; rel = committed_q[0];
    for (int w = 1; w <= 3; w++) begin
      i_valid = 1; i_data = $urandom; i_last = (w == 3); i_err = 0;
      if (w == 3) begin
        i_release = 1; i_release_len = 9'(committed_q.pop_front());
      end
      step();
    end
    idle(2);
    checks++;
    if (o_used !== 14'(u0 + 3 - rel)) begin
      errors++; $display("FAIL release_commit_used: got %0d expected %0d", o_used, u0 + 3 - rel);
    end
    drain();
  endtask

  task automatic test_random();
    int len, err_at;
    rand_mode = 1;
    repeat (150) begin
      len = $urandom_range(1, 8);
      err_at = ($urandom_range(0, 9) == 0) ? $urandom_range(1, len) : 0;
      send_frame(len, err_at);
      idle($urandom_range(0, 3));
    end
    rand_mode = 0;
    drain();
    checks++;
    if (o_used !== 14'd0 || o_frame_cnt !== 16'(m_frames) || o_drop_cnt !== 16'(m_drops)) begin
      errors++;
      $display("FAIL random_totals: got used %0d frames %0d drops %0d expected 0 %0d %0d",
               o_used, o_frame_cnt, o_drop_cnt, m_frames, m_drops);
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int w = 1; w <= 3; w++) begin
      i_valid = 1; i_data = $urandom; i_last = 0; i_err = 0;
      step();
    end
    i_valid = 0;
    #2 i_rst_n = 0;
    #1;
    checks++;
    if ({o_wr, o_desc_valid, o_used, o_frame_cnt, o_drop_cnt, o_addr_wr} !== '0) begin
      errors++;
      $display("FAIL midframe_reset: got wr %0b used %0d frames %0d drops %0d addr %0d expected all 0",
               o_wr, o_used, o_frame_cnt, o_drop_cnt, o_addr_wr);
    end
    model_reset();
    #2 i_rst_n = 1;
    for (int w = 0; w < 2; w++) begin
      i_valid = 1; i_data = $urandom; i_last = (w == 1); i_err = 0;
      step();
      checks++;
      if (o_wr !== 1'b1 || o_addr_wr !== 13'(w)) begin
        errors++; $display("FAIL post_reset_addr %0d: got wr %0b addr %0d expected 1 %0d", w, o_wr, o_addr_wr, w);
      end
    end
    idle(2);
    checks++;
    if (o_frame_cnt !== 16'd1 || o_drop_cnt !== 16'd0 || o_used !== 14'd2) begin
      errors++;
      $display("FAIL post_reset_counts: got frames %0d drops %0d used %0d expected 1 0 2", o_frame_cnt, o_drop_cnt, o_used);
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; rand_mode = 0;
    i_rst_n = 0; i_valid = 0; i_data = '0; i_last = 0; i_err = 0;
    i_desc_ready = 0; i_release = 0; i_release_len = '0;
    model_reset();
    test_reset();
    test_basic();
    test_err();
    test_wrap();
    test_overflow();
    test_oversize();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
